// File: rtl/sync_counter_pkg.sv
// Shared types and helpers for the multi-channel snapshot counter.
package sync_counter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } snap_state_t;

    // Readout index width; a single channel still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One live event counter with sticky overflow, wrap or saturate at all-ones.
module counter_channel #(
    parameter int COUNTER_BITS  = 32,
    parameter int SATURATE      = 0,
    parameter int CLEAR_ON_SNAP = 0
) (
    input  logic                    tclk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear,
    input  logic                    capture,
    output logic [COUNTER_BITS-1:0] count,
    output logic                    ovf
);

    localparam logic [COUNTER_BITS-1:0] ALL_ONES = '1;
    localparam logic [COUNTER_BITS-1:0] ONE      = {{(COUNTER_BITS-1){1'b0}}, 1'b1};

    logic at_max;
    logic wrap_evt;

    assign at_max   = (count == ALL_ONES);
    assign wrap_evt = enable & at_max;

    always_ff @(posedge tclk) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            ovf   <= 1'b0;
        end else if (capture && (CLEAR_ON_SNAP != 0)) begin
            // The capture-cycle enable belongs to the next interval.
            count <= enable ? ONE : '0;
            ovf   <= 1'b0;
        end else begin
            if (enable) begin
                if (!at_max)
                    count <= count + ONE;
                else if (SATURATE == 0)
                    count <= '0;
            end
            ovf <= (ovf & ~capture) | wrap_evt;
        end
    end

endmodule

// File: rtl/multi_sync_counter.sv
// N_CH event counters with atomic snapshot into shadow registers and a
// valid/ready readout stream of one channel per beat.
//
//   state  | meaning
//   IDLE   | counters running, waiting for a snapshot rising edge
//   STREAM | shadow registers being streamed out, new edges are dropped
module multi_sync_counter
    import sync_counter_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int COUNTER_BITS  = 32,
    parameter int SATURATE      = 0,
    parameter int CLEAR_ON_SNAP = 0
) (
    input  logic                        tclk,
    input  logic                        reset,
    input  logic [N_CH-1:0]             enable,
    input  logic                        clear,
    input  logic                        snapshot,
    output logic                        snap_valid,
    input  logic                        snap_ready,
    output logic [idx_width(N_CH)-1:0]  snap_channel,
    output logic [COUNTER_BITS-1:0]     snap_data,
    output logic                        snap_overflow,
    output logic                        snap_last,
    output logic                        snap_missed
);

    localparam int             IW       = idx_width(N_CH);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_CH - 1);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);

    snap_state_t               state;
    logic                      snap_prev;
    logic                      capture_edge;
    logic                      capture;
    logic [IW-1:0]             idx;
    logic [COUNTER_BITS-1:0]   live [N_CH];
    logic [N_CH-1:0]           ovf;
    logic [COUNTER_BITS-1:0]   shadow [N_CH];
    logic [N_CH-1:0]           shadow_ovf;

    assign capture_edge = snapshot & ~snap_prev;
    assign capture      = capture_edge & (state == IDLE);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        counter_channel #(
            .COUNTER_BITS  (COUNTER_BITS),
            .SATURATE      (SATURATE),
            .CLEAR_ON_SNAP (CLEAR_ON_SNAP)
        ) u_ch (
            .tclk    (tclk),
            .reset   (reset),
            .enable  (enable[g]),
            .clear   (clear),
            .capture (capture),
            .count   (live[g]),
            .ovf     (ovf[g])
        );
    end

    always_ff @(posedge tclk) begin
        if (reset) begin
            state       <= IDLE;
            snap_prev   <= 1'b1;
            idx         <= '0;
            snap_valid  <= 1'b0;
            snap_last   <= 1'b0;
            snap_missed <= 1'b0;
            shadow_ovf  <= '0;
            for (int i = 0; i < N_CH; i++)
                shadow[i] <= '0;
        end else begin
            snap_prev   <= snapshot;
            snap_missed <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture_edge) begin
                        for (int i = 0; i < N_CH; i++)
                            shadow[i] <= live[i];
                        shadow_ovf <= ovf;
                        idx        <= '0;
                        snap_valid <= 1'b1;
                        snap_last  <= (N_CH == 1);
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (capture_edge)
                        snap_missed <= 1'b1;
                    if (snap_ready) begin
                        if (snap_last) begin
                            state      <= IDLE;
                            snap_valid <= 1'b0;
                            snap_last  <= 1'b0;
                            idx        <= '0;
                        end else begin
                            idx       <= idx + IDX_ONE;
                            snap_last <= ((idx + IDX_ONE) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign snap_channel  = idx;
    assign snap_data     = shadow[idx];
    assign snap_overflow = shadow_ovf[idx];

endmodule
